noc_output_arbiter: RTL and testbench

Per-output-port allocator for the mesh router. It sits between the five input-port LBDR/FIFO stages and one crossbar output. Among input ports whose LBDR has selected this output, it grants round-robin on HEADER flits. It holds the grant until that packet's TAIL flit has moved, and paces flit transfers with a credit counter that tracks free slots in the downstream input buffer.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/noc_output_arbiter.sv | 130 +++++++++++++
 tb/tb_noc_output_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings, mesh port indices and the
// output-allocator state type.
package noc_pkg;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    localparam int unsigned PORT_N = 0;
    localparam int unsigned PORT_E = 1;
    localparam int unsigned PORT_W = 2;
    localparam int unsigned PORT_S = 3;
    localparam int unsigned PORT_L = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Shared with the switch allocator.
module rr_arbiter #(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output allocator: round-robin grant on HEADER flits, held until the
// owner's TAIL moves; transfers paced by downstream buffer credits.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned N_IN      = 5,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_IN-1:0]     req,
    input  logic [3*N_IN-1:0]   flit_id,
    input  logic                credit_in,
    output logic [N_IN-1:0]     grant,
    output logic [N_IN-1:0]     rd_en,
    output logic [2:0]          xbar_sel,
    output logic                valid_out,
    output logic [CNT_W-1:0]    credit_cnt,
    output logic                credit_err
);

    localparam int unsigned IDX_W = 3;

    arb_state_t       state_q, state_d;
    logic [N_IN-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [N_IN-1:0]  hdr_req;
    logic [N_IN-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             owner_req;
    logic [2:0]       owner_flit;
    logic             xfer;

    always_comb begin
        hdr_req    = '0;
        owner_req  = 1'b0;
        owner_flit = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            hdr_req[i] = req[i] && (flit_id[3*i +: 3] == HEADER);
            if (sel_q == IDX_W'(i)) begin
                owner_req  = req[i];
                owner_flit = flit_id[3*i +: 3];
            end
        end
    end

    rr_arbiter #(
        .N     (N_IN),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (hdr_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        rd_en   = '0;
        xfer    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = BUSY;
                    grant_d = arb_gnt;
                    sel_d   = arb_idx;
                end
            end
            BUSY: begin
                // Gated by rst so no FIFO is popped while the router is in reset.
                if (!rst && owner_req && (cnt_q != '0)) begin
                    xfer  = 1'b1;
                    rd_en = grant_q;
                    if (owner_flit == TAIL) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = (sel_q == IDX_W'(N_IN - 1)) ? '0 : sel_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (credit_in && !xfer) begin
            if (cnt_q == CNT_W'(BUF_DEPTH)) err_d = 1'b1;
            else                            cnt_d = cnt_q + CNT_W'(1);
        end else if (xfer && !credit_in) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= CNT_W'(BUF_DEPTH);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign grant      = grant_q;
    assign xbar_sel   = sel_q;
    assign valid_out  = |rd_en;
    assign credit_cnt = cnt_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: a per-cycle vector table plus
// hand-written credit-stall and bubble sequences.
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam logic [2:0] H  = HEADER;
    localparam logic [2:0] P  = PAYLOAD;
    localparam logic [2:0] T  = TAIL;
    localparam logic [2:0] XX = 3'h7;   // xbar_sel not checked

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [14:0] flit_id;
    logic        credit_in;
    logic [4:0]  grant;
    logic [4:0]  rd_en;
    logic [2:0]  xbar_sel;
    logic        valid_out;
    logic [2:0]  credit_cnt;
    logic        credit_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic        rst;
        logic [4:0]  req;
        logic [14:0] fid;
        logic        cin;
        logic [4:0]  g;
        logic [4:0]  rd;
        logic [2:0]  xs;
        logic [2:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    noc_output_arbiter #(
        .N_IN      (5),
        .BUF_DEPTH (4),
        .CNT_W     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flit_id    (flit_id),
        .credit_in  (credit_in),
        .grant      (grant),
        .rd_en      (rd_en),
        .xbar_sel   (xbar_sel),
        .valid_out  (valid_out),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] fv(input logic [2:0] l, s, w, e, n);
        return {l, s, w, e, n};
    endfunction

    function automatic logic [14:0] fa(input logic [2:0] t);
        return {t, t, t, t, t};
    endfunction

    task automatic chk(input string name, input int unsigned row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] rq, input logic [14:0] f,
                       input logic ci, input logic [4:0] g, input logic [4:0] rd,
                       input logic [2:0] xs, input logic [2:0] cnt, input logic err);
        vec_t v;
        v.rst = r; v.req = rq; v.fid = f; v.cin = ci;
        v.g = g; v.rd = rd; v.xs = xs; v.cnt = cnt; v.err = err;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, check outputs before the next edge, then advance.
    task automatic cyc(input int unsigned row, input vec_t v);
        rst = v.rst; req = v.req; flit_id = v.fid; credit_in = v.cin;
        #2;
        chk("grant", row, 32'(grant), 32'(v.g));
        chk("rd_en", row, 32'(rd_en), 32'(v.rd));
        chk("valid_out", row, 32'(valid_out), 32'(v.rd != 5'b0));
        if (v.xs != XX) chk("xbar_sel", row, 32'(xbar_sel), 32'(v.xs));
        chk("credit_cnt", row, 32'(credit_cnt), 32'(v.cnt));
        chk("credit_err", row, 32'(credit_err), 32'(v.err));
        @(posedge clk);
        #1;
    endtask

    task automatic hc(input int unsigned row, input logic [4:0] rq, input logic [14:0] f,
                      input logic ci, input logic [4:0] g, input logic [4:0] rd,
                      input logic [2:0] xs, input logic [2:0] cnt, input logic err);
        vec_t v;
        v.rst = 1'b0; v.req = rq; v.fid = f; v.cin = ci;
        v.g = g; v.rd = rd; v.xs = xs; v.cnt = cnt; v.err = err;
        cyc(row, v);
    endtask

    initial begin
        rst = 1'b1; req = '0; flit_id = '0; credit_in = 1'b0;

        //   rst  req       flit_id               cin  grant     rd_en     xs  cnt err
        add(1, 5'b11111, fa(H),                0, 5'b00000, 5'b00000, 0,  4, 0);
        // single W packet
        add(0, 5'b00100, fa(H),                0, 5'b00000, 5'b00000, 0,  4, 0);
        add(0, 5'b00100, fa(H),                0, 5'b00100, 5'b00100, 2,  4, 0);
        add(0, 5'b00100, fa(P),                0, 5'b00100, 5'b00100, 2,  3, 0);
        add(0, 5'b00100, fa(T),                0, 5'b00100, 5'b00100, 2,  2, 0);
        // non-header filter, then S granted
        add(0, 5'b00010, fa(P),                1, 5'b00000, 5'b00000, XX, 1, 0);
        add(0, 5'b00010, fa(P),                1, 5'b00000, 5'b00000, XX, 2, 0);
        add(0, 5'b01000, fa(H),                1, 5'b00000, 5'b00000, XX, 3, 0);
        add(0, 5'b01000, fa(H),                0, 5'b01000, 5'b01000, 3,  4, 0);
        add(0, 5'b01000, fa(T),                0, 5'b01000, 5'b01000, 3,  3, 0);
        // ptr=4: N beats S by wrap-around
        add(0, 5'b01001, fa(H),                1, 5'b00000, 5'b00000, XX, 2, 0);
        add(0, 5'b01001, fa(H),                1, 5'b00001, 5'b00001, 0,  3, 0);
        add(0, 5'b01001, fv(H, H, H, H, T),    0, 5'b00001, 5'b00001, 0,  3, 0);
        // S packet with simultaneous pop and credit at cnt=2
        add(0, 5'b01000, fa(H),                1, 5'b00000, 5'b00000, XX, 2, 0);
        add(0, 5'b01000, fa(H),                0, 5'b01000, 5'b01000, 3,  3, 0);
        add(0, 5'b01000, fa(P),                1, 5'b01000, 5'b01000, 3,  2, 0);
        add(0, 5'b01000, fa(T),                1, 5'b01000, 5'b01000, 3,  2, 0);
        add(0, 5'b00000, fa(P),                1, 5'b00000, 5'b00000, XX, 2, 0);
        add(0, 5'b00000, fa(P),                1, 5'b00000, 5'b00000, XX, 3, 0);
        // reset after two flits of an E packet
        add(0, 5'b00010, fa(H),                0, 5'b00000, 5'b00000, XX, 4, 0);
        add(0, 5'b00010, fa(H),                0, 5'b00010, 5'b00010, 1,  4, 0);
        add(0, 5'b00010, fa(P),                0, 5'b00010, 5'b00010, 1,  3, 0);
        add(1, 5'b00010, fa(P),                0, 5'b00010, 5'b00000, 1,  2, 0);
        add(0, 5'b10001, fa(H),                0, 5'b00000, 5'b00000, 0,  4, 0);
        add(0, 5'b10001, fa(H),                0, 5'b00001, 5'b00001, 0,  4, 0);
        add(0, 5'b10001, fv(H, H, H, H, T),    0, 5'b00001, 5'b00001, 0,  3, 0);
        add(1, 5'b00000, fa(H),                0, 5'b00000, 5'b00000, XX, 2, 0);
        // round-robin N, E, L, N from ptr=0
        add(0, 5'b10011, fa(H),                0, 5'b00000, 5'b00000, 0,  4, 0);
        add(0, 5'b10011, fa(H),                0, 5'b00001, 5'b00001, 0,  4, 0);
        add(0, 5'b10011, fv(H, H, H, H, T),    0, 5'b00001, 5'b00001, 0,  3, 0);
        add(0, 5'b10011, fa(H),                1, 5'b00000, 5'b00000, XX, 2, 0);
        add(0, 5'b10011, fa(H),                1, 5'b00010, 5'b00010, 1,  3, 0);
        add(0, 5'b10011, fv(H, H, H, T, H),    1, 5'b00010, 5'b00010, 1,  3, 0);
        add(0, 5'b10011, fa(H),                1, 5'b00000, 5'b00000, XX, 3, 0);
        add(0, 5'b10011, fa(H),                0, 5'b10000, 5'b10000, 4,  4, 0);
        add(0, 5'b10011, fv(T, H, H, H, H),    0, 5'b10000, 5'b10000, 4,  3, 0);
        add(0, 5'b10011, fa(H),                1, 5'b00000, 5'b00000, XX, 2, 0);
        add(0, 5'b10011, fa(H),                1, 5'b00001, 5'b00001, 0,  3, 0);
        add(0, 5'b10011, fv(H, H, H, H, T),    1, 5'b00001, 5'b00001, 0,  3, 0);
        add(0, 5'b00000, fa(H),                1, 5'b00000, 5'b00000, XX, 3, 0);
        // credit overflow while idle
        add(0, 5'b00000, fa(H),                1, 5'b00000, 5'b00000, XX, 4, 0);
        add(0, 5'b00000, fa(H),                0, 5'b00000, 5'b00000, XX, 4, 1);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) cyc(i, vecs[i]);

        // Credit stall: 6-flit W packet, no credits returned after the first 4 flits.
        hc(100, 5'b00100, fa(H), 0, 5'b00000, 5'b00000, XX, 4, 1);
        hc(101, 5'b00100, fa(H), 0, 5'b00100, 5'b00100, 2,  4, 1);
        hc(102, 5'b00100, fa(P), 0, 5'b00100, 5'b00100, 2,  3, 1);
        hc(103, 5'b00100, fa(P), 0, 5'b00100, 5'b00100, 2,  2, 1);
        hc(104, 5'b00100, fa(P), 0, 5'b00100, 5'b00100, 2,  1, 1);
        for (int unsigned k = 0; k < 3; k++)
            hc(105 + k, 5'b00100, fa(P), 0, 5'b00100, 5'b00000, 2, 0, 1);
        // upstream bubble coincides with a returned credit: grant held, nothing moves
        hc(110, 5'b00000, fa(P), 1, 5'b00100, 5'b00000, 2,  0, 1);
        hc(111, 5'b00100, fa(P), 0, 5'b00100, 5'b00100, 2,  1, 1);
        hc(112, 5'b00100, fa(T), 0, 5'b00100, 5'b00000, 2,  0, 1);
        hc(113, 5'b00100, fa(T), 1, 5'b00100, 5'b00000, 2,  0, 1);
        hc(114, 5'b00100, fa(T), 0, 5'b00100, 5'b00100, 2,  1, 1);
        hc(115, 5'b00000, fa(H), 0, 5'b00000, 5'b00000, XX, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
